// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package hazard_pkg;

   typedef enum logic {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } state_t;

   localparam logic [4:0] REG_X0              = 5'd0;
   localparam int         DEFAULT_MEM_TIMEOUT = 64;

   // A load in EX whose rd feeds a source the ID instruction actually reads.
   function automatic logic load_use_hit(
      input logic       memread,
      input logic [4:0] rd,
      input logic [4:0] rs1,
      input logic [4:0] rs2,
      input logic       uses_rs2
   );
      return memread && (rd != REG_X0) &&
             ((rd == rs1) || (uses_rs2 && (rd == rs2)));
   endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] count
);

   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/stall controller: load-use bubbles, taken-branch flush and a memory-wait freeze
// with sticky timeout. Define HAZARD_PERF_CNT_EN to add stall/flush performance counters.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int MEM_TIMEOUT = DEFAULT_MEM_TIMEOUT,
   parameter int CNT_W       = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [4:0]       id_rs1_i,
   input  logic [4:0]       id_rs2_i,
   input  logic             id_uses_rs2_i,
   input  logic             ex_memread_i,
   input  logic [4:0]       ex_rd_i,
   input  logic             branch_taken_i,
   input  logic             mem_req_i,
   input  logic             mem_ack_i,
   output logic             pc_write_o,
   output logic             ifid_write_o,
   output logic             ifid_flush_o,
   output logic             idex_write_o,
   output logic             idex_bubble_o,
   output logic             exmem_write_o,
   output logic             err_o
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0] stall_cycles_o,
   output logic [CNT_W-1:0] flush_count_o
`endif
);

   localparam int WAIT_W = $clog2(MEM_TIMEOUT) + 1;

   state_t            state;
   logic              frozen;
   logic              load_use;
   logic              wait_inc;
   logic              wait_clr;
   logic              timeout_hit;
   logic [WAIT_W-1:0] wait_count;

   assign frozen   = !mem_ack_i && ((state == MEM_WAIT) || mem_req_i);
   assign load_use = load_use_hit(ex_memread_i, ex_rd_i, id_rs1_i, id_rs2_i, id_uses_rs2_i);

   // NOTE: every output gets a default first so no path through the block can infer a latch.
   always_comb begin
      pc_write_o    = 1'b1;
      ifid_write_o  = 1'b1;
      ifid_flush_o  = 1'b0;
      idex_write_o  = 1'b1;
      idex_bubble_o = 1'b0;
      exmem_write_o = 1'b1;
      if (rst_i) begin
         // Reset holds the pipeline in its free-running state regardless of inputs.
      end else if (frozen) begin
         pc_write_o    = 1'b0;
         ifid_write_o  = 1'b0;
         idex_write_o  = 1'b0;
         exmem_write_o = 1'b0;
      end else if (load_use) begin
         pc_write_o    = 1'b0;
         ifid_write_o  = 1'b0;
         idex_bubble_o = 1'b1;
      end else if (branch_taken_i) begin
         ifid_flush_o  = 1'b1;
      end
   end

   assign wait_inc    = (state == MEM_WAIT) && !mem_ack_i;
   assign wait_clr    = (state == RUN) || mem_ack_i;
   assign timeout_hit = wait_inc && (wait_count >= WAIT_W'(MEM_TIMEOUT - 1));

   sat_counter #(.W(WAIT_W)) u_wait_cnt (
      .clk   (clk_i),
      .rst   (rst_i),
      .inc   (wait_inc),
      .clr   (wait_clr),
      .count (wait_count)
   );

   // NOTE: only control state is reset; no storage arrays exist here that would need it.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state <= RUN;
         err_o <= 1'b0;
      end else begin
         case (state)
            RUN:      if (mem_req_i && !mem_ack_i) state <= MEM_WAIT;
            MEM_WAIT: if (mem_ack_i)               state <= RUN;
         endcase
         if (timeout_hit) err_o <= 1'b1;
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk_i),
      .rst   (rst_i),
      .inc   (!pc_write_o),
      .clr   (1'b0),
      .count (stall_cycles_o)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk_i),
      .rst   (rst_i),
      .inc   (ifid_flush_o),
      .clr   (1'b0),
      .count (flush_count_o)
   );
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table, directed multi-cycle sequences, random vs model.
module tb_hazard_ctrl;

   localparam int TIMEOUT = 4;
   localparam int CW      = 32;

   // Output vector order: {pc, ifid, flush, idex, bubble, exmem}
   localparam logic [5:0] ALL_EN = 6'b110101;
   localparam logic [5:0] FLUSH  = 6'b111101;
   localparam logic [5:0] STALL  = 6'b000111;
   localparam logic [5:0] FREEZE = 6'b000000;

   logic       clk_i = 1'b0;
   logic       rst_i = 1'b1;
   logic [4:0] id_rs1_i = '0, id_rs2_i = '0, ex_rd_i = '0;
   logic       id_uses_rs2_i = 1'b0, ex_memread_i = 1'b0, branch_taken_i = 1'b0;
   logic       mem_req_i = 1'b0, mem_ack_i = 1'b0;
   logic       pc_write_o, ifid_write_o, ifid_flush_o, idex_write_o, idex_bubble_o;
   logic       exmem_write_o, err_o;
`ifdef HAZARD_PERF_CNT_EN
   logic [CW-1:0] stall_cycles_o, flush_count_o;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   hazard_ctrl #(.MEM_TIMEOUT(TIMEOUT), .CNT_W(CW)) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .id_rs1_i       (id_rs1_i),
      .id_rs2_i       (id_rs2_i),
      .id_uses_rs2_i  (id_uses_rs2_i),
      .ex_memread_i   (ex_memread_i),
      .ex_rd_i        (ex_rd_i),
      .branch_taken_i (branch_taken_i),
      .mem_req_i      (mem_req_i),
      .mem_ack_i      (mem_ack_i),
      .pc_write_o     (pc_write_o),
      .ifid_write_o   (ifid_write_o),
      .ifid_flush_o   (ifid_flush_o),
      .idex_write_o   (idex_write_o),
      .idex_bubble_o  (idex_bubble_o),
      .exmem_write_o  (exmem_write_o),
      .err_o          (err_o)
`ifdef HAZARD_PERF_CNT_EN
      ,
      .stall_cycles_o (stall_cycles_o),
      .flush_count_o  (flush_count_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      string      name;
      logic       memread;
      logic [4:0] rd, rs1, rs2;
      logic       uses2, branch, req, ack;
      logic [5:0] exp;
   } vec_t;

   function automatic logic [5:0] outs();
      return {pc_write_o, ifid_write_o, ifid_flush_o, idex_write_o, idex_bubble_o, exmem_write_o};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic memread, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic uses2, input logic branch,
                        input logic req, input logic ack);
      ex_memread_i = memread; ex_rd_i = rd; id_rs1_i = rs1; id_rs2_i = rs2;
      id_uses_rs2_i = uses2; branch_taken_i = branch; mem_req_i = req; mem_ack_i = ack;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic next();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset();
      #2 rst_i = 1'b1;
      idle();
      #2 rst_i = 1'b0;
      next();
   endtask

   // Reference model: expected outputs from the hazard rules, given whether a memory wait is pending.
   function automatic logic [5:0] model_out(input bit waiting, input logic memread,
                                            input logic [4:0] rd, input logic [4:0] rs1,
                                            input logic [4:0] rs2, input logic uses2,
                                            input logic branch, input logic req, input logic ack);
      bit hit;
      if (!ack && (waiting || req)) return FREEZE;
      hit = memread && rd != 0 && (rd == rs1 || (uses2 && rd == rs2));
      if (hit) return STALL;
      return branch ? FLUSH : ALL_EN;
   endfunction

   vec_t vecs[11];

   initial begin
      bit          waiting;
      int          wait_n;
      bit          m_err;
      int          m_stall, m_flush;
      logic [5:0]  e;

      vecs[0]  = '{"idle",          0,  0,  0,  0, 0, 0, 0, 0, ALL_EN};
      vecs[1]  = '{"lu_rs1",        1,  5,  5,  0, 0, 0, 0, 0, STALL};
      vecs[2]  = '{"lu_rs2",        1,  9,  3,  9, 1, 0, 0, 0, STALL};
      vecs[3]  = '{"rs2_unused",    1,  7,  1,  7, 0, 0, 0, 0, ALL_EN};
      vecs[4]  = '{"rd_x0",         1,  0,  0,  0, 1, 0, 0, 0, ALL_EN};
      vecs[5]  = '{"no_memread",    0,  5,  5,  5, 1, 0, 0, 0, ALL_EN};
      vecs[6]  = '{"branch",        0,  0,  0,  0, 0, 1, 0, 0, FLUSH};
      vecs[7]  = '{"lu_and_branch", 1, 12, 12,  0, 0, 1, 0, 0, STALL};
      vecs[8]  = '{"single_access", 0,  0,  0,  0, 0, 0, 1, 1, ALL_EN};
      vecs[9]  = '{"single_lu",     1,  4,  2,  4, 1, 0, 1, 1, STALL};
      vecs[10] = '{"rd_mismatch",   1,  6,  5,  4, 1, 1, 0, 0, FLUSH};

      // Reset state: outputs forced free-running even with hazards on the inputs.
      drive(1, 5, 5, 5, 1, 1, 1, 0);
      #2;
      check("reset_outs", 32'(outs()), 32'(ALL_EN));
      check("reset_err", 32'(err_o), 0);
      #10 rst_i = 1'b0;
      idle();
      next();
`ifdef HAZARD_PERF_CNT_EN
      check("reset_stall_cnt", stall_cycles_o, 0);
      check("reset_flush_cnt", flush_count_o, 0);
`endif

      foreach (vecs[i]) begin
         drive(vecs[i].memread, vecs[i].rd, vecs[i].rs1, vecs[i].rs2,
               vecs[i].uses2, vecs[i].branch, vecs[i].req, vecs[i].ack);
         #2;
         check(vecs[i].name, 32'(outs()), 32'(vecs[i].exp));
         next();
      end
      do_reset();

      // Load-use stall lasts one cycle; bubble clears MemRead so the next cycle runs.
      drive(1, 5, 5, 0, 0, 0, 0, 0);
      #1 check("lu_cycle", 32'(outs()), 32'(STALL));
      next();
      drive(0, 0, 5, 0, 0, 0, 0, 0);
      #1 check("lu_after", 32'(outs()), 32'(ALL_EN));
      next();

      // Memory wait: ack low for 3 cycles, then high.
      drive(0, 0, 0, 0, 0, 0, 1, 0);
      for (int c = 0; c < 3; c++) begin
         #1 check($sformatf("mem_freeze_%0d", c), 32'(outs()), 32'(FREEZE));
         next();
      end
      mem_ack_i = 1'b1;
      #1 check("mem_ack_cycle", 32'(outs()), 32'(ALL_EN));
      next();
      idle();
      #1 check("mem_back_run", 32'(outs()), 32'(ALL_EN));
      check("mem_no_err", 32'(err_o), 0);
      next();

      // Freeze outranks load-use and branch.
      drive(1, 8, 8, 0, 0, 1, 1, 0);
      #1 check("freeze_over_lu", 32'(outs()), 32'(FREEZE));
      next();
      drive(0, 0, 0, 0, 0, 0, 0, 1);
      #1 check("freeze_release", 32'(outs()), 32'(ALL_EN));
      next();
      idle();

      // Timeout: err rises only after the 4th MEM_WAIT cycle without ack, then sticks.
      drive(0, 0, 0, 0, 0, 0, 1, 0);
      next();
      for (int c = 1; c <= TIMEOUT; c++) begin
         #1 check($sformatf("tmo_err_low_%0d", c), 32'(err_o), 0);
         next();
      end
      check("tmo_err_set", 32'(err_o), 1);
      check("tmo_still_frozen", 32'(outs()), 32'(FREEZE));
      mem_ack_i = 1'b1;
      next();
      idle();
      #1 check("tmo_err_sticky", 32'(err_o), 1);
      check("tmo_run_after_ack", 32'(outs()), 32'(ALL_EN));
      drive(0, 0, 0, 0, 0, 0, 1, 0);
      next();
      next();
      // Asynchronous reset mid-wait, away from the clock edge.
      #2 rst_i = 1'b1;
      #1 check("async_rst_err", 32'(err_o), 0);
      check("async_rst_outs", 32'(outs()), 32'(ALL_EN));
      idle();
      #1 rst_i = 1'b0;
      #1 check("async_rst_state_run", 32'(outs()), 32'(ALL_EN));
      next();
      #1 check("async_rst_run_edge", 32'(outs()), 32'(ALL_EN));

`ifdef HAZARD_PERF_CNT_EN
      do_reset();
      drive(1, 3, 3, 0, 0, 0, 0, 0);
      next();
      drive(0, 0, 0, 0, 0, 0, 1, 0);
      next(); next(); next();
      drive(0, 0, 0, 0, 0, 1, 1, 1);
      next();
      drive(0, 0, 0, 0, 0, 1, 0, 0);
      next();
      idle();
      #1 check("perf_stall_cycles", stall_cycles_o, 4);
      check("perf_flush_count", flush_count_o, 2);
`endif

      // Randomized run against the reference model.
      do_reset();
      waiting = 0; wait_n = 0; m_err = 0; m_stall = 0; m_flush = 0;
      for (int c = 0; c < 600; c++) begin
         logic req, ack;
         req = waiting ? 1'b1 : ($urandom_range(0, 3) == 0);
         ack = waiting ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 0);
         drive($urandom_range(0, 1), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               5'($urandom_range(0, 3)), $urandom_range(0, 1), ($urandom_range(0, 2) == 0),
               req, ack);
         #1;
         e = model_out(waiting, ex_memread_i, ex_rd_i, id_rs1_i, id_rs2_i, id_uses_rs2_i,
                       branch_taken_i, mem_req_i, mem_ack_i);
         check($sformatf("rand_outs_%0d", c), 32'(outs()), 32'(e));
         check($sformatf("rand_err_%0d", c), 32'(err_o), 32'(m_err));
         if (!e[5]) m_stall++;
         if (e[3])  m_flush++;
         if (waiting) begin
            if (ack) begin
               waiting = 0;
               wait_n = 0;
            end else begin
               wait_n++;
               if (wait_n >= TIMEOUT) m_err = 1;
            end
         end else if (req && !ack) begin
            waiting = 1;
            wait_n = 0;
         end
         next();
      end
`ifdef HAZARD_PERF_CNT_EN
      check("rand_stall_cycles", stall_cycles_o, 32'(m_stall));
      check("rand_flush_count", flush_count_o, 32'(m_flush));
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
